// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: PC source select encoding, the NOP
// instruction and the misaligned-target trap vector.
package riscv_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_RSVD   = 2'b11
    } pc_src_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID outputs.
// misalign_trap exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    import riscv_pkg::*;

    logic                     stall;
    pc_src_t                  pc_src;
    logic [ADDRESS_WIDTH-1:0] branch_target;
    logic [ADDRESS_WIDTH-1:0] jalr_target;
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0]    imem_rd;
    logic [DATA_WIDTH-1:0]    instr_d;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_d;
    logic                     valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                     misalign_trap;
`endif

    // The fetch stage is the master: it drives the address and IF/ID outputs.
    modport master (
        input  stall, pc_src, branch_target, jalr_target, imem_rd,
        output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d
`ifdef FETCH_MISALIGN_TRAP_EN
        , output misalign_trap
`endif
    );

    modport slave (
        output stall, pc_src, branch_target, jalr_target, imem_rd,
        input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d
`ifdef FETCH_MISALIGN_TRAP_EN
        , input misalign_trap
`endif
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program-counter flop: async active-low reset to RESET_VECTOR, loads d when en.
module pc_reg #(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] d,
    output logic [ADDRESS_WIDTH-1:0] q
);

    // PC state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VECTOR;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC mux and IF/ID register.
// Optional FETCH_MISALIGN_TRAP_EN diverts misaligned redirects to TRAP_VECTOR.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    logic [ADDRESS_WIDTH-1:0] pc_s;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_s;
    logic [ADDRESS_WIDTH-1:0] target_s;
    logic [ADDRESS_WIDTH-1:0] next_pc_s;
    logic                     redirect_s;
    logic                     pc_en_s;
    logic                     misaligned_s;

    assign pc_plus4_s    = pc_s + ADDRESS_WIDTH'(4);
    assign bus.imem_addr = pc_s;

    // Redirect target selection; JALR drops bit 0, reserved encoding acts as sequential
    always_comb begin
        redirect_s = 1'b0;
        target_s   = pc_plus4_s;
        case (bus.pc_src)
            PC_BRANCH: begin
                redirect_s = 1'b1;
                target_s   = bus.branch_target;
            end
            PC_JALR: begin
                redirect_s = 1'b1;
                target_s   = {bus.jalr_target[ADDRESS_WIDTH-1:1], 1'b0};
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = pc_plus4_s;
            end
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned_s = redirect_s && (target_s[1:0] != 2'b00);
`else
    assign misaligned_s = 1'b0;
`endif

    // Next-PC mux: redirect (or trap) beats stall beats sequential
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (misaligned_s) begin
            next_pc_s = ADDRESS_WIDTH'(TRAP_VECTOR);
        end else if (redirect_s) begin
            next_pc_s = target_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    assign pc_en_s = redirect_s || !bus.stall;

    pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_VECTOR  (RESET_VECTOR)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en_s),
        .d     (next_pc_s),
        .q     (pc_s)
    );

    // IF/ID pipeline register: a redirect flushes it to a NOP bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.instr_d    <= DATA_WIDTH'(NOP_INSTR);
            bus.pc_d       <= {ADDRESS_WIDTH{1'b0}};
            bus.pc_plus4_d <= {ADDRESS_WIDTH{1'b0}};
            bus.valid_d    <= 1'b0;
        end else if (redirect_s) begin
            bus.instr_d    <= DATA_WIDTH'(NOP_INSTR);
            bus.pc_d       <= {ADDRESS_WIDTH{1'b0}};
            bus.pc_plus4_d <= {ADDRESS_WIDTH{1'b0}};
            bus.valid_d    <= 1'b0;
        end else if (bus.stall) begin
            bus.instr_d    <= bus.instr_d;
            bus.pc_d       <= bus.pc_d;
            bus.pc_plus4_d <= bus.pc_plus4_d;
            bus.valid_d    <= bus.valid_d;
        end else begin
            bus.instr_d    <= bus.imem_rd;
            bus.pc_d       <= pc_s;
            bus.pc_plus4_d <= pc_plus4_s;
            bus.valid_d    <= 1'b1;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Single-cycle trap pulse accompanying the diverted redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.misalign_trap <= 1'b0;
        end else begin
            bus.misalign_trap <= misaligned_s;
        end
    end
`endif

endmodule
